// File: rtl/pair_triple_stimulus_checker.sv
// Stimulus generator and checker for the 3-bit majority (pair/triple) detector.
// Optional build macro PTD_LOOPBACK_EN: loops the stimulus back through an internal majority.
module pair_triple_stimulus_checker #(
  parameter int unsigned MAX_COUNT = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      vec_reg, vec_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      fail_vec_reg, fail_vec_next;
  logic            run;
  logic            loop;
  logic            result;

  function automatic logic majority(input logic [2:0] v);
    return (v[0] & v[1]) | (v[2] & (v[0] | v[1]));
  endfunction

  function automatic logic [6:0] seg_digit(input logic [2:0] d);
    logic [6:0] s;
    case (d)
      3'd0:    s = 7'h3F;
      3'd1:    s = 7'h06;
      3'd2:    s = 7'h5B;
      3'd3:    s = 7'h4F;
      3'd4:    s = 7'h66;
      3'd5:    s = 7'h6D;
      3'd6:    s = 7'h7D;
      default: s = 7'h07;
    endcase
    return s;
  endfunction

  assign run  = ui_in[0] & ena;
  assign loop = ui_in[1];

`ifdef PTD_LOOPBACK_EN
  // Looped-back result is one register behind the stimulus; ui_in[2] injects a fault.
  logic lb_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lb_reg <= 1'b0;
    else     lb_reg <= majority(uio_out[2:0]);
  end
  assign result = lb_reg ^ ui_in[2];
  wire unused_in = &{1'b0, ui_in[7:3], uio_in, 1'b0};
`else
  assign result = uio_in[3];
  wire unused_in = &{1'b0, ui_in[7:2], uio_in[7:4], uio_in[2:0], 1'b0};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      vec_reg      <= 3'd0;
      cnt_reg      <= '0;
      fail_vec_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      vec_reg      <= vec_next;
      cnt_reg      <= cnt_next;
      fail_vec_reg <= fail_vec_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    vec_next      = vec_reg;
    cnt_next      = cnt_reg;
    fail_vec_next = fail_vec_reg;
    // Dropping run overrides everything, including a coincident sample cycle.
    if (!run) begin
      state_next    = IDLE;
      vec_next      = 3'd0;
      cnt_next      = '0;
      fail_vec_next = 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = DRIVE;
          vec_next   = 3'd0;
          cnt_next   = '0;
        end
        DRIVE: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            if (result != majority(vec_reg)) begin
              state_next    = FAIL;
              fail_vec_next = vec_reg;
            end else if (vec_reg == 3'd7) begin
              state_next = DONE;
            end else begin
              vec_next = vec_reg + 3'd1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (loop) begin
            state_next = DRIVE;
            vec_next   = 3'd0;
            cnt_next   = '0;
          end
        end
        FAIL: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are pure decode of registered state, vec and fail_vec.
  always_comb begin
    uo_out = {1'b0, seg_digit(vec_reg)};
    case (state_reg)
      DONE:    uo_out = 8'hF3;
      FAIL:    uo_out = 8'h71;
      default: ;
    endcase
  end

  assign uio_out = {1'b0, fail_vec_reg, 1'b0, vec_reg};
  assign uio_oe  = 8'b0111_0111;

endmodule
